// File: rtl/sub_align_64.sv
`default_nettype none
// ============================================================================
// Module   : sub_align_64
// Purpose  : Back-end of the 64-bit pipelined subtractor. Delays the operand
//            pair and its valid tag by LAT cycles so they line up with the
//            external negator output neg_b, forms a + neg_b with status flags,
//            and buffers results in a first-word-fall-through FIFO with a
//            ready/valid output and sticky overflow-drop detection.
// Ports    : clk, rst (async, active-high)
//            in_valid, in_a, in_b  - operand pair (in_b also feeds negator)
//            neg_b                 - negator output, -in_b from LAT edges ago
//            out_valid/out_ready   - FIFO head handshake
//            out_diff, out_zero, out_neg, out_ovf, out_borrow - head entry
//            count                 - FIFO occupancy
//            drop_err              - sticky: result lost on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module sub_align_64 #(
    parameter int LAT   = 7,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [63:0]   in_a,
    input  logic [63:0]   in_b,
    input  logic [63:0]   neg_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_diff,
    output logic          out_zero,
    output logic          out_neg,
    output logic          out_ovf,
    output logic          out_borrow,
    output logic [CW-1:0] count,
    output logic          drop_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 68;  // {diff, zero, neg, ovf, borrow}

    // ------------------------------------------------------------------
    // Alignment delay line (never stalls, the negator cannot stall)
    // ------------------------------------------------------------------
    logic [LAT-1:0]        valid_q, valid_d;
    logic [LAT-1:0][63:0]  a_q, a_d;
    logic [LAT-1:0][63:0]  b_q, b_d;

    always_comb begin
        valid_d    = valid_q;
        a_d        = a_q;
        b_d        = b_q;
        valid_d[0] = in_valid;
        a_d[0]     = in_a;
        b_d[0]     = in_b;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            a_d[i]     = a_q[i-1];
            b_d[i]     = b_q[i-1];
        end
    end

    // Only the valid tags need reset; stale data behind a cleared tag is inert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // ------------------------------------------------------------------
    // Compute in the tail cycle
    // ------------------------------------------------------------------
    logic          tail_valid;
    logic [63:0]   tail_a;
    logic [63:0]   tail_b;
    logic [63:0]   diff;
    logic          flag_zero;
    logic          flag_neg;
    logic          flag_ovf;
    logic          flag_borrow;
    logic [EW-1:0] entry;

    always_comb begin
        tail_valid  = valid_q[LAT-1];
        tail_a      = a_q[LAT-1];
        tail_b      = b_q[LAT-1];
        diff        = tail_a + neg_b;
        flag_zero   = (diff == 64'd0);
        flag_neg    = diff[63];
        // Flags use the delayed b rather than neg_b: -0 and -MIN_INT are
        // their own negations, so neg_b alone cannot tell the sign of b.
        flag_ovf    = (tail_a[63] != tail_b[63]) && (diff[63] != tail_a[63]);
        flag_borrow = (tail_a < tail_b);
        entry       = {diff, flag_zero, flag_neg, flag_ovf, flag_borrow};
    end

    // ------------------------------------------------------------------
    // Result FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;
    logic          drop_now;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(DEPTH));
        do_pop     = !fifo_empty && out_ready;
        // A full FIFO still accepts a push when the head leaves the same edge.
        do_push    = tail_valid && (!fifo_full || do_pop);
        drop_now   = tail_valid && fifo_full && !do_pop;

        wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end

        drop_d     = drop_q || drop_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry falls through; reads zero while empty
    // ------------------------------------------------------------------
    logic [EW-1:0] head;

    always_comb begin
        head      = fifo_empty ? '0 : mem_q[rd_ptr_q];
        out_valid = !fifo_empty;
        {out_diff, out_zero, out_neg, out_ovf, out_borrow} = head;
        count     = count_q;
        drop_err  = drop_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_align_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_align_64
// Purpose  : Directed self-checking bench for sub_align_64. Includes a
//            behavioural 7-stage negator feeding neg_b.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_align_64;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] neg_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_diff;
    logic        out_zero;
    logic        out_neg;
    logic        out_ovf;
    logic        out_borrow;
    logic [2:0]  count;
    logic        drop_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Negator model: LAT registers, free running, no reset.
    logic [63:0] neg_pipe [LAT];
    always @(posedge clk) begin
        neg_pipe[0] <= 64'd0 - in_b;
        for (int i = 1; i < LAT; i++) neg_pipe[i] <= neg_pipe[i-1];
    end
    assign neg_b = neg_pipe[LAT-1];

    sub_align_64 #(.LAT(LAT), .DEPTH(4), .CW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_b       (in_b),
        .neg_b      (neg_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .out_borrow (out_borrow),
        .count      (count),
        .drop_err   (drop_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one pair for one sampling edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step(1);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a head entry, check it, then pop it.
    // flags = {zero, neg, ovf, borrow}
    task automatic expect_head(input string tag, input logic [63:0] d, input logic [3:0] flags);
        for (int t = 0; t < 20 && !out_valid; t++) step(1);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_diff"},  out_diff, d);
        check({tag, "_flags"}, 64'({out_zero, out_neg, out_ovf, out_borrow}), 64'(flags));
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic saw_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        step(3);

        // Reset state
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count),     64'd0);
        check("rst_drop",  64'(drop_err),  64'd0);
        check("rst_diff",  out_diff,       64'd0);
        rst = 1'b0;
        step(2);

        // Single op with exact latency: sampling edge counts as edge 1
        send(64'd10, 64'd3);
        step(6);
        check("lat7_valid", 64'(out_valid), 64'd0);
        step(1);
        check("lat8_valid", 64'(out_valid), 64'd1);
        check("lat8_count", 64'(count),     64'd1);
        expect_head("op10m3", 64'd7, 4'b0000);
        check("op10m3_cnt", 64'(count),     64'd0);

        // Sign, borrow, zero
        send(64'd3, 64'd10);
        expect_head("op3m10", 64'hFFFF_FFFF_FFFF_FFF9, 4'b0101);
        send(64'd5, 64'd5);
        expect_head("op5m5", 64'd0, 4'b1000);

        // Overflow boundaries
        send(64'd0, 64'h8000_0000_0000_0000);
        expect_head("op0mmin", 64'h8000_0000_0000_0000, 4'b0111);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_head("opmaxm1", 64'h8000_0000_0000_0000, 4'b0111);

        // Back-to-back stream, consumer always ready
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) begin
                in_valid = 1'b1;
                in_a     = 64'(c + 100);
                in_b     = 64'(c);
            end else begin
                in_valid = 1'b0;
            end
            step(1);
            if (c + 1 >= 8 && c + 1 <= 17) begin
                check("strm_valid", 64'(out_valid), 64'd1);
                check("strm_diff",  out_diff,       64'd100);
                check("strm_count", 64'(count),     64'd1);
            end else begin
                check("strm_idle",  64'(out_valid), 64'd0);
            end
        end
        out_ready = 1'b0;

        // Overflow: six pairs into a stalled FIFO
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a     = 64'(1000 + 2 * i);
            in_b     = 64'(i);
            step(1);
        end
        in_valid = 1'b0;
        step(10);
        check("ovf_count", 64'(count),    64'd4);
        check("ovf_drop",  64'(drop_err), 64'd1);
        for (int i = 0; i < 4; i++) expect_head("drain", 64'(1000 + i), 4'b0000);
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_count", 64'(count),     64'd0);
        check("drop_sticky", 64'(drop_err),  64'd1);

        // Reset clears the sticky drop flag
        rst = 1'b1;
        step(1);
        check("rst2_drop",  64'(drop_err), 64'd0);
        rst = 1'b0;
        step(1);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 64'(1000 + 2 * i);
            in_b     = 64'(i);
            step(1);
        end
        in_valid = 1'b0;
        step(10);
        check("full_count", 64'(count), 64'd4);
        send(64'd2000, 64'd0);
        step(6);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("pp_count", 64'(count),    64'd4);
        check("pp_drop",  64'(drop_err), 64'd0);
        expect_head("pp1", 64'd1001, 4'b0000);
        expect_head("pp2", 64'd1002, 4'b0000);
        expect_head("pp3", 64'd1003, 4'b0000);
        expect_head("pp4", 64'd2000, 4'b0000);

        // Reset while two pairs are in flight
        send(64'd1, 64'd1);
        send(64'd2, 64'd1);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int t = 0; t < 15; t++) begin
            step(1);
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_rst_valid", 64'(saw_valid), 64'd0);
        check("mid_rst_count", 64'(count),     64'd0);
        check("mid_rst_drop",  64'(drop_err),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
